// File: rtl/servo_pkg.sv
// servo_pkg: shared types and constants for the servo scheduler.
//   state_t        FSM states of the scheduler
//   DC_W / DATA_W  duty-cycle command width / accelerometer sample width
//   *_DC_DEF       default duty-cycle bounds and centre (clock counts)
//   AX_*           axis tags carried through the mapping pipeline
package servo_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    MAP_X  = 3'd2,
    MAP_Y  = 3'd3,
    MAP_Z  = 3'd4,
    COMMIT = 3'd5
  } state_t;

  localparam int DC_W   = 32;
  localparam int DATA_W = 16;

  localparam int MIN_DC_DEF    = 25_000;
  localparam int CENTER_DC_DEF = 75_000;
  localparam int MAX_DC_DEF    = 125_000;

  localparam logic [1:0] AX_X = 2'd0;
  localparam logic [1:0] AX_Y = 2'd1;
  localparam logic [1:0] AX_Z = 2'd2;

endpackage

// File: rtl/servo_axis_map.sv
// servo_axis_map: shared two-stage accelerometer-to-duty-cycle mapper.
//   p0: clamp sample to +/-ACCEL_RANGE, flag clamping
//   p1: CENTER_DC + sample*(MAX_DC-CENTER_DC)/ACCEL_RANGE, limited to [MIN_DC, MAX_DC]
// Ports:
//   clk, rst          clock, synchronous active-high reset (valid pipeline only)
//   in_vld, in_axis   input strobe and axis tag
//   sample            signed accelerometer sample
//   out_vld, out_axis result strobe and axis tag (two cycles after input)
//   out_dc, out_sat   mapped duty cycle and clamp flag for that axis
module servo_axis_map
  import servo_pkg::*;
#(
  parameter int MIN_DC      = MIN_DC_DEF,
  parameter int CENTER_DC   = CENTER_DC_DEF,
  parameter int MAX_DC      = MAX_DC_DEF,
  parameter int ACCEL_RANGE = 2000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic [1:0]               in_axis,
  input  logic signed [DATA_W-1:0] sample,
  output logic                     out_vld,
  output logic [1:0]               out_axis,
  output logic [DC_W-1:0]          out_dc,
  output logic                     out_sat
);

  localparam logic signed [39:0] RANGE  = 40'(ACCEL_RANGE);
  localparam logic signed [39:0] SPAN   = 40'(MAX_DC - CENTER_DC);
  localparam logic signed [39:0] CENTER = 40'(CENTER_DC);
  localparam logic signed [39:0] DC_MIN = 40'(MIN_DC);
  localparam logic signed [39:0] DC_MAX = 40'(MAX_DC);

  function automatic logic signed [39:0] clamp_sample(input logic signed [39:0] s);
    if (s > RANGE)       return RANGE;
    else if (s < -RANGE) return -RANGE;
    else                 return s;
  endfunction

  function automatic logic [DC_W-1:0] sat_dc(input logic signed [39:0] v);
    logic signed [39:0] lim;
    if (v > DC_MAX)      lim = DC_MAX;
    else if (v < DC_MIN) lim = DC_MIN;
    else                 lim = v;
    return lim[DC_W-1:0];
  endfunction

  logic signed [39:0] samp_ext;
  logic signed [39:0] samp_p0;
  logic               sat_p0;
  logic [1:0]         axis_p0;
  logic               vld_p0;
  logic signed [39:0] prod_p1;
  logic signed [39:0] mapped_p1;
  logic [DC_W-1:0]    dc_p1;
  logic               sat_p1;
  logic [1:0]         axis_p1;
  logic               vld_p1;

  assign samp_ext = $signed({{(40-DATA_W){sample[DATA_W-1]}}, sample});

  // stage p0: clamp
  always_ff @(posedge clk) begin
    samp_p0 <= clamp_sample(samp_ext);
    sat_p0  <= (samp_ext > RANGE) || (samp_ext < -RANGE);
    axis_p0 <= in_axis;
  end

  // stage p1: scale, divide (truncates toward zero), offset, limit
  assign prod_p1   = samp_p0 * SPAN;
  assign mapped_p1 = CENTER + (prod_p1 / RANGE);

  always_ff @(posedge clk) begin
    dc_p1   <= sat_dc(mapped_p1);
    sat_p1  <= sat_p0;
    axis_p1 <= axis_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= in_vld;
      vld_p1 <= vld_p0;
    end
  end

  assign out_vld  = vld_p1;
  assign out_axis = axis_p1;
  assign out_dc   = dc_p1;
  assign out_sat  = sat_p1;

endmodule

// File: rtl/servo_scheduler.sv
// servo_scheduler: turns accelerometer samples (tracking mode) or manual
// step pulses (manual mode) into three registered PWM duty-cycle commands.
// Optional build macro: SERVO_SCHEDULER_SLEW_LIMIT_EN limits each committed
// change to SLEW_STEP per axis; without it the target is loaded directly.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sample_valid, data_x/y/z accelerometer strobe and signed samples
//   mode                     0 = tracking, 1 = manual (sampled in IDLE)
//   man_inc, man_dec         per-axis manual step pulses (bit0/1/2 = X/Y/Z)
//   dc_x/y/z, dc_valid       duty-cycle commands and their update pulse
//   busy, sat, overrun       FSM active, per-axis clamp flags, sticky drop flag
module servo_scheduler
  import servo_pkg::*;
#(
  parameter int FREQ        = 25_000_000,
  parameter int MIN_DC      = MIN_DC_DEF,
  parameter int CENTER_DC   = CENTER_DC_DEF,
  parameter int MAX_DC      = MAX_DC_DEF,
  parameter int ACCEL_RANGE = 2000,
  parameter int STEP        = 10_000,
  parameter int SLEW_STEP   = 2_500
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] data_x,
  input  logic signed [DATA_W-1:0] data_y,
  input  logic signed [DATA_W-1:0] data_z,
  input  logic                     mode,
  input  logic [2:0]               man_inc,
  input  logic [2:0]               man_dec,
  output logic [DC_W-1:0]          dc_x,
  output logic [DC_W-1:0]          dc_y,
  output logic [DC_W-1:0]          dc_z,
  output logic                     dc_valid,
  output logic                     busy,
  output logic [2:0]               sat,
  output logic                     overrun
);

  function automatic logic [DC_W-1:0] man_step(input logic [DC_W-1:0] dc,
                                               input logic inc, input logic dec);
    if (inc && !dec)
      return (dc > DC_W'(MAX_DC - STEP)) ? DC_W'(MAX_DC) : dc + DC_W'(STEP);
    else if (dec && !inc)
      return (dc < DC_W'(MIN_DC + STEP)) ? DC_W'(MIN_DC) : dc - DC_W'(STEP);
    else
      return dc;
  endfunction

`ifdef SERVO_SCHEDULER_SLEW_LIMIT_EN
  function automatic logic [DC_W-1:0] slew(input logic [DC_W-1:0] prev,
                                           input logic [DC_W-1:0] tgt);
    logic signed [DC_W:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, prev});
    if (diff > SLEW_STEP)       return prev + DC_W'(SLEW_STEP);
    else if (diff < -SLEW_STEP) return prev - DC_W'(SLEW_STEP);
    else                        return tgt;
  endfunction
`else
  function automatic logic [DC_W-1:0] slew(input logic [DC_W-1:0] prev,
                                           input logic [DC_W-1:0] tgt);
    return (prev == tgt) ? prev : tgt;
  endfunction
`endif

  state_t state_q, state_d;
  logic   phase_q, phase_d;

  logic signed [DATA_W-1:0] samp_x_p0, samp_y_p0, samp_z_p0;
  logic [DC_W-1:0]          tgt_x, tgt_y;

  logic                     map_in_vld;
  logic [1:0]               map_in_axis;
  logic signed [DATA_W-1:0] map_sample;
  logic                     map_vld;
  logic [1:0]               map_axis;
  logic [DC_W-1:0]          map_dc;
  logic                     map_sat;
  logic                     accept;
  logic                     commit_now;

  assign busy       = (state_q != IDLE);
  assign accept     = (state_q == IDLE) && !mode && sample_valid;
  assign commit_now = (state_q == MAP_Z) && phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Each axis is fed to the mapper one cycle before its MAP state so the
  // result lands in that state's second cycle; Z therefore commits on the
  // edge into COMMIT and dc_valid is seen during COMMIT.
  always_comb begin
    state_d     = state_q;
    phase_d     = 1'b0;
    map_in_vld  = 1'b0;
    map_in_axis = AX_X;
    map_sample  = samp_x_p0;
    case (state_q)
      IDLE:   if (accept) state_d = LATCH;
      LATCH: begin
        state_d    = MAP_X;
        map_in_vld = 1'b1;
      end
      MAP_X: begin
        if (phase_q) begin
          state_d     = MAP_Y;
          map_in_vld  = 1'b1;
          map_in_axis = AX_Y;
          map_sample  = samp_y_p0;
        end else begin
          phase_d = 1'b1;
        end
      end
      MAP_Y: begin
        if (phase_q) begin
          state_d     = MAP_Z;
          map_in_vld  = 1'b1;
          map_in_axis = AX_Z;
          map_sample  = samp_z_p0;
        end else begin
          phase_d = 1'b1;
        end
      end
      MAP_Z: begin
        if (phase_q) state_d = COMMIT;
        else         phase_d = 1'b1;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  servo_axis_map #(
    .MIN_DC      (MIN_DC),
    .CENTER_DC   (CENTER_DC),
    .MAX_DC      (MAX_DC),
    .ACCEL_RANGE (ACCEL_RANGE)
  ) u_map (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (map_in_vld),
    .in_axis  (map_in_axis),
    .sample   (map_sample),
    .out_vld  (map_vld),
    .out_axis (map_axis),
    .out_dc   (map_dc),
    .out_sat  (map_sat)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      samp_x_p0 <= data_x;
      samp_y_p0 <= data_y;
      samp_z_p0 <= data_z;
    end
    if (map_vld && map_axis == AX_X) tgt_x <= map_dc;
    if (map_vld && map_axis == AX_Y) tgt_y <= map_dc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dc_x     <= DC_W'(CENTER_DC);
      dc_y     <= DC_W'(CENTER_DC);
      dc_z     <= DC_W'(CENTER_DC);
      dc_valid <= 1'b0;
      sat      <= 3'b000;
      overrun  <= 1'b0;
    end else begin
      dc_valid <= 1'b0;
      if (busy && sample_valid) overrun <= 1'b1;
      if (map_vld) begin
        case (map_axis)
          AX_X:    sat[0] <= map_sat;
          AX_Y:    sat[1] <= map_sat;
          default: sat[2] <= map_sat;
        endcase
      end
      if ((state_q == IDLE) && mode && ((|man_inc) || (|man_dec))) begin
        dc_x     <= man_step(dc_x, man_inc[0], man_dec[0]);
        dc_y     <= man_step(dc_y, man_inc[1], man_dec[1]);
        dc_z     <= man_step(dc_z, man_inc[2], man_dec[2]);
        dc_valid <= 1'b1;
      end
      if (commit_now) begin
        dc_x     <= slew(dc_x, tgt_x);
        dc_y     <= slew(dc_y, tgt_y);
        dc_z     <= slew(dc_z, map_dc);
        dc_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_servo_scheduler.sv
// Directed bench for servo_scheduler in its default build (no slew limit).
module tb_servo_scheduler;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_valid;
  logic signed [15:0] data_x, data_y, data_z;
  logic               mode;
  logic [2:0]         man_inc, man_dec;
  logic [31:0]        dc_x, dc_y, dc_z;
  logic               dc_valid;
  logic               busy;
  logic [2:0]         sat;
  logic               overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  servo_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .data_x       (data_x),
    .data_y       (data_y),
    .data_z       (data_z),
    .mode         (mode),
    .man_inc      (man_inc),
    .man_dec      (man_dec),
    .dc_x         (dc_x),
    .dc_y         (dc_y),
    .dc_z         (dc_z),
    .dc_valid     (dc_valid),
    .busy         (busy),
    .sat          (sat),
    .overrun      (overrun)
  );

  // Presents one sample in IDLE and returns the number of cycles from the
  // accepting cycle to the first dc_valid (capped at 20).
  task automatic send_sample(input int x, input int y, input int z, output int lat);
    @(posedge clk); #1;
    data_x = 16'(x); data_y = 16'(y); data_z = 16'(z);
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    lat = 1;
    while (dc_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 1'b0; sample_valid = 1'b0;
    data_x = '0; data_y = '0; data_z = '0; man_inc = '0; man_dec = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++; if (dc_x !== 32'd75000) begin n_fail++; $display("FAIL reset_dc_x got %0d exp 75000", dc_x); end
    n_tests++; if (dc_y !== 32'd75000) begin n_fail++; $display("FAIL reset_dc_y got %0d exp 75000", dc_y); end
    n_tests++; if (dc_z !== 32'd75000) begin n_fail++; $display("FAIL reset_dc_z got %0d exp 75000", dc_z); end
    n_tests++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dc_valid got %b exp 0", dc_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (sat !== 3'b000) begin n_fail++; $display("FAIL reset_sat got %b exp 000", sat); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
  endtask

  task automatic test_track;
    int lat;
    send_sample(0, 2000, -2000, lat);
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL track_latency got %0d exp 8", lat); end
    n_tests++; if (dc_x !== 32'd75000) begin n_fail++; $display("FAIL track_dc_x got %0d exp 75000", dc_x); end
    n_tests++; if (dc_y !== 32'd125000) begin n_fail++; $display("FAIL track_dc_y got %0d exp 125000", dc_y); end
    n_tests++; if (dc_z !== 32'd25000) begin n_fail++; $display("FAIL track_dc_z got %0d exp 25000", dc_z); end
    n_tests++; if (sat !== 3'b000) begin n_fail++; $display("FAIL track_sat got %b exp 000", sat); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL track_busy_commit got %b exp 1", busy); end
    @(posedge clk); #1;
    n_tests++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL track_pulse_width got %b exp 0", dc_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL track_idle got %b exp 0", busy); end
  endtask

  task automatic test_clamp;
    int lat;
    send_sample(3000, -1, -2500, lat);
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL clamp_latency got %0d exp 8", lat); end
    n_tests++; if (dc_x !== 32'd125000) begin n_fail++; $display("FAIL clamp_dc_x got %0d exp 125000", dc_x); end
    n_tests++; if (dc_y !== 32'd74975) begin n_fail++; $display("FAIL clamp_dc_y got %0d exp 74975", dc_y); end
    n_tests++; if (dc_z !== 32'd25000) begin n_fail++; $display("FAIL clamp_dc_z got %0d exp 25000", dc_z); end
    n_tests++; if (sat !== 3'b101) begin n_fail++; $display("FAIL clamp_sat got %b exp 101", sat); end
  endtask

  task automatic test_overrun;
    int first;
    int pulses;
    first = 0; pulses = 0;
    @(posedge clk); #1;
    data_x = 16'sd1000; data_y = 16'sd0; data_z = 16'sd0;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (dc_valid === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (k == 3) begin
        data_x = -16'sd1000; data_y = 16'sd2000; data_z = 16'sd2000;
        sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    n_tests++; if (first !== 8) begin n_fail++; $display("FAIL overrun_latency got %0d exp 8", first); end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL overrun_pulses got %0d exp 1", pulses); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag got %b exp 1", overrun); end
    n_tests++; if (dc_x !== 32'd100000) begin n_fail++; $display("FAIL overrun_dc_x got %0d exp 100000", dc_x); end
    n_tests++; if (dc_y !== 32'd75000) begin n_fail++; $display("FAIL overrun_dc_y got %0d exp 75000", dc_y); end
    n_tests++; if (dc_z !== 32'd75000) begin n_fail++; $display("FAIL overrun_dc_z got %0d exp 75000", dc_z); end
  endtask

  task automatic test_manual;
    int lat;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send_sample(2000, 0, 0, lat);
    n_tests++; if (dc_x !== 32'd125000) begin n_fail++; $display("FAIL manual_setup_dc_x got %0d exp 125000", dc_x); end
    @(posedge clk); #1;
    mode = 1'b1;
    man_inc = 3'b001; sample_valid = 1'b1; data_x = -16'sd2000;
    @(posedge clk); #1;
    man_inc = 3'b000; sample_valid = 1'b0;
    n_tests++; if (dc_valid !== 1'b1) begin n_fail++; $display("FAIL manual_inc_sat_pulse got %b exp 1", dc_valid); end
    n_tests++; if (dc_x !== 32'd125000) begin n_fail++; $display("FAIL manual_inc_sat_dc_x got %0d exp 125000", dc_x); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL manual_ignore_busy got %b exp 0", busy); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL manual_ignore_overrun got %b exp 0", overrun); end
    man_inc = 3'b010; man_dec = 3'b010;
    @(posedge clk); #1;
    man_inc = 3'b000; man_dec = 3'b000;
    n_tests++; if (dc_valid !== 1'b1) begin n_fail++; $display("FAIL manual_both_pulse got %b exp 1", dc_valid); end
    n_tests++; if (dc_y !== 32'd75000) begin n_fail++; $display("FAIL manual_both_dc_y got %0d exp 75000", dc_y); end
    man_dec = 3'b100;
    @(posedge clk); #1;
    man_dec = 3'b000;
    n_tests++; if (dc_z !== 32'd65000) begin n_fail++; $display("FAIL manual_dec_dc_z got %0d exp 65000", dc_z); end
    n_tests++; if (dc_valid !== 1'b1) begin n_fail++; $display("FAIL manual_dec_pulse got %b exp 1", dc_valid); end
    @(posedge clk); #1;
    n_tests++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL manual_idle_pulse got %b exp 0", dc_valid); end
  endtask

  task automatic test_busy_discard;
    int lat;
    @(posedge clk); #1;
    mode = 1'b0;
    data_x = -16'sd2000; data_y = 16'sd0; data_z = 16'sd0;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    mode = 1'b1;
    man_dec = 3'b111;
    @(posedge clk); #1;
    man_dec = 3'b000;
    lat = 2;
    while (dc_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL busy_latency got %0d exp 8", lat); end
    n_tests++; if (dc_x !== 32'd25000) begin n_fail++; $display("FAIL busy_dc_x got %0d exp 25000", dc_x); end
    n_tests++; if (dc_z !== 32'd75000) begin n_fail++; $display("FAIL busy_dc_z got %0d exp 75000", dc_z); end
    man_inc = 3'b001;
    @(posedge clk); #1;
    man_inc = 3'b000;
    n_tests++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL busy_commit_manual got %b exp 0", dc_valid); end
    man_inc = 3'b001;
    @(posedge clk); #1;
    man_inc = 3'b000;
    n_tests++; if (dc_x !== 32'd35000) begin n_fail++; $display("FAIL busy_after_manual_dc_x got %0d exp 35000", dc_x); end
    n_tests++; if (dc_valid !== 1'b1) begin n_fail++; $display("FAIL busy_after_manual_pulse got %b exp 1", dc_valid); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    mode = 1'b0;
    data_x = 16'sd2000; data_y = 16'sd2000; data_z = 16'sd2000;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b exp 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (dc_x !== 32'd75000) begin n_fail++; $display("FAIL midrst_dc_x got %0d exp 75000", dc_x); end
    n_tests++; if (dc_y !== 32'd75000) begin n_fail++; $display("FAIL midrst_dc_y got %0d exp 75000", dc_y); end
    n_tests++; if (dc_z !== 32'd75000) begin n_fail++; $display("FAIL midrst_dc_z got %0d exp 75000", dc_z); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy); end
    for (int k = 0; k < 10; k++) begin
      if (dc_valid === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_pulses got %0d exp 0", pulses); end
  endtask

  initial begin
    test_reset;
    test_track;
    test_clamp;
    test_overrun;
    test_manual;
    test_busy_discard;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_scheduler.md
SERVO_SCHEDULER -- requirements
Module: servo_scheduler

Interface
REQ-001 Parameter FREQ, default 25_000_000, system clock frequency in Hz, informational only.
REQ-002 Parameter MIN_DC / CENTER_DC / MAX_DC, defaults 25_000 / 75_000 / 125_000, duty-cycle bounds and centre in clock counts.
REQ-003 Parameter ACCEL_RANGE, default 2000, full-scale accelerometer magnitude.
REQ-004 Parameter STEP, default 10_000, manual increment per pulse; SLEW_STEP, default 2_500, maximum per-commit change.
REQ-005 Port clk, in, 1, single system clock; all logic on its rising edge.
REQ-006 Port rst, in, 1, reset; synchronous, active-high.
REQ-007 Port sample_valid, in, 1, single-cycle strobe marking new data_x/y/z.
REQ-008 Ports data_x, data_y, data_z, in, 16 each, signed two's-complement accelerometer samples.
REQ-009 Port mode, in, 1, 0 = accelerometer tracking, 1 = manual.
REQ-010 Ports man_inc, man_dec, in, 3 each, debounced single-cycle pulses; bit 0/1/2 = X/Y/Z.
REQ-011 Ports dc_x, dc_y, dc_z, out, 32 each, registered duty-cycle commands to the PWM channels.
REQ-012 Port dc_valid, out, 1, one-cycle pulse when dc_x/y/z are updated.
REQ-013 Port busy, out, 1, high whenever the FSM is not in IDLE.
REQ-014 Port sat, out, 3, per-axis flag: last accelerometer sample for that axis was clamped.
REQ-015 Port overrun, out, 1, sticky flag: a sample_valid was dropped.

Function
REQ-016 FSM states IDLE, LATCH, MAP_X, MAP_Y, MAP_Z, COMMIT; MAP_X through MAP_Z last 2 cycles each, all others 1 cycle.
REQ-017 IDLE with mode=0 and sample_valid=1: capture data_x/y/z, go to LATCH, then MAP_X, MAP_Y, MAP_Z, COMMIT, IDLE.
REQ-018 dc_valid pulses exactly 8 cycles after the cycle in which sample_valid was accepted.
REQ-019 Mapping for each axis: clamp the sample to [-ACCEL_RANGE, +ACCEL_RANGE], set that sat bit if clamping occurred, else clear it, then target = CENTER_DC + sample*(MAX_DC-CENTER_DC)/ACCEL_RANGE.
REQ-020 Mapping arithmetic: signed, at least 40-bit intermediate, division truncated toward zero, result then clamped to [MIN_DC, MAX_DC].
REQ-021 A single shared mapping unit serves all three axes in sequence; no per-axis duplication.
REQ-022 sample_valid while busy=1: sample dropped, overrun set, in-flight sequence unaffected.
REQ-023 mode is sampled only in IDLE; a mode change mid-sequence takes effect after COMMIT.
REQ-024 IDLE with mode=1: sample_valid ignored, overrun not set.
REQ-025 IDLE with mode=1, per axis: man_inc adds STEP saturating at MAX_DC; man_dec subtracts STEP saturating at MIN_DC; both high leaves the value unchanged.
REQ-026 Manual updates register in one cycle; dc_valid pulses the cycle after any man_inc or man_dec bit is high, including saturated or no-change cases.
REQ-027 Manual pulses arriving while busy=1 are discarded.

Reset
REQ-028 On rst=1 at a clock edge: FSM to IDLE, dc_x/y/z = CENTER_DC, dc_valid=0, busy=0, sat=0, overrun=0.
REQ-029 Reset mid-sequence aborts it; no dc_valid is issued for the aborted sample.

Configuration
REQ-030 Macro SERVO_SCHEDULER_SLEW_LIMIT_EN defined: in COMMIT each axis moves from its previous dc toward target by at most SLEW_STEP.
REQ-031 Macro undefined: COMMIT loads target directly; SLEW_STEP unused; manual mode identical in both builds.

Structure
REQ-032 Package servo_pkg holds the FSM state enum, the DC width constant (32), the sample width constant (16) and the default MIN/CENTER/MAX_DC values.
REQ-033 Sub-module servo_axis_map holds the 2-cycle registered clamp/multiply/divide pipeline, instantiated once.

Verification
REQ-034 Reset, then mode=0, sample x=0, y=2000, z=-2000 -> no slew: dc=75000/125000/25000 at +8 cycles; with SLEW_LIMIT_EN: 75000/77500/72500.
REQ-035 No slew, sample x=3000, y=-1, z=-2500 -> dc_x=125000, dc_y=74975, dc_z=25000, sat=3'b101.
REQ-036 sample_valid at cycle N and N+3 -> one dc_valid at N+8, overrun=1, values from the first sample.
REQ-037 mode=1, dc_x=125000, man_inc[0] -> dc_x stays 125000 with dc_valid pulse; man_inc[1]&man_dec[1] -> dc_y unchanged; man_dec[2] -> dc_z=65000.
REQ-038 rst asserted during MAP_Y -> next cycle all dc=75000, busy=0, no dc_valid in the following 10 cycles.
